// File: rtl/tri_setup_if.sv
// Vertex-in / coefficient-out bundle for the triangle setup stage.
// master drives vertices, start and out_ready; slave is tri_setup itself.
interface tri_setup_if;
  logic               start;
  logic [9:0]         ax, ay, bx, by, cx, cy;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic signed [10:0] a0, b0, a1, b1, a2, b2;
  logic signed [20:0] c0, c1, c2;
  logic signed [21:0] area;
  logic               culled;

  modport master (
    output start, ax, ay, bx, by, cx, cy, out_ready,
    input  busy, out_valid, a0, b0, a1, b1, a2, b2, c0, c1, c2, area, culled
  );

  modport slave (
    input  start, ax, ay, bx, by, cx, cy, out_ready,
    output busy, out_valid, a0, b0, a1, b1, a2, b2, c0, c1, c2, area, culled
  );
endinterface

// File: rtl/tri_setup.sv
// Once-per-frame triangle setup: edge coefficients and doubled area via one shared shift-add multiplier.
// Optional macro TRI_SETUP_CULL_EN drops negative-area triangles instead of flipping their orientation.
module tri_setup (
  input  logic       clk_pix,
  input  logic       rst,
  tri_setup_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LATCH, MUL, SUM, DONE} state_t;

  state_t             state_reg;
  logic [9:0]         ax_reg, ay_reg, bx_reg, by_reg, cx_reg, cy_reg;
  logic signed [10:0] a_reg [3];
  logic signed [10:0] b_reg [3];
  logic signed [20:0] c_reg [3];
  logic [2:0]         prod_cnt_reg;
  logic [3:0]         step_reg;
  logic signed [21:0] acc_reg;
  logic signed [21:0] first_reg;

  logic signed [10:0] a_out_reg [3];
  logic signed [10:0] b_out_reg [3];
  logic signed [20:0] c_out_reg [3];
  logic signed [21:0] area_reg;
  logic               busy_reg, out_valid_reg, culled_reg;

  logic signed [10:0] mcand, mplier;
  logic signed [21:0] mcand_ext, partial, acc_base, acc_next, c_diff, area_sum;
  logic               area_zero, area_neg, drop, flip;

  // Product order pairs up as the two halves of c0, c1, c2.
  always_comb begin
    mcand  = '0;
    mplier = '0;
    unique case (prod_cnt_reg)
      3'd0:    begin mcand = {1'b0, ax_reg}; mplier = {1'b0, by_reg}; end
      3'd1:    begin mcand = {1'b0, bx_reg}; mplier = {1'b0, ay_reg}; end
      3'd2:    begin mcand = {1'b0, bx_reg}; mplier = {1'b0, cy_reg}; end
      3'd3:    begin mcand = {1'b0, cx_reg}; mplier = {1'b0, by_reg}; end
      3'd4:    begin mcand = {1'b0, cx_reg}; mplier = {1'b0, ay_reg}; end
      default: begin mcand = {1'b0, ax_reg}; mplier = {1'b0, cy_reg}; end
    endcase
  end

  // The multiplier's top bit carries negative weight, so its partial product is subtracted.
  always_comb begin
    mcand_ext = {{11{mcand[10]}}, mcand};
    partial   = mcand_ext <<< step_reg;
    acc_base  = (step_reg == 4'd0) ? '0 : acc_reg;
    acc_next  = acc_base;
    if (mplier[step_reg]) begin
      acc_next = (step_reg == 4'd10) ? acc_base - partial : acc_base + partial;
    end
    c_diff = first_reg - acc_next;
  end

  assign area_sum  = $signed({c_reg[0][20], c_reg[0]}) + $signed({c_reg[1][20], c_reg[1]})
                   + $signed({c_reg[2][20], c_reg[2]});
  assign area_zero = (area_sum == 22'sd0);
  assign area_neg  = area_sum[21];

`ifdef TRI_SETUP_CULL_EN
  assign drop = area_zero | area_neg;
  assign flip = 1'b0;
`else
  assign drop = area_zero;
  assign flip = area_neg;
`endif

  logic signed [10:0] a_sel [3];
  logic signed [10:0] b_sel [3];
  logic signed [20:0] c_sel [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_orient
      assign a_sel[gi] = flip ? -a_reg[gi] : a_reg[gi];
      assign b_sel[gi] = flip ? -b_reg[gi] : b_reg[gi];
      assign c_sel[gi] = flip ? -c_reg[gi] : c_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state_reg     <= IDLE;
      {ax_reg, ay_reg, bx_reg, by_reg, cx_reg, cy_reg} <= '0;
      prod_cnt_reg  <= '0;
      step_reg      <= '0;
      acc_reg       <= '0;
      first_reg     <= '0;
      area_reg      <= '0;
      busy_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      culled_reg    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        a_reg[i]     <= '0;
        b_reg[i]     <= '0;
        c_reg[i]     <= '0;
        a_out_reg[i] <= '0;
        b_out_reg[i] <= '0;
        c_out_reg[i] <= '0;
      end
    end else begin
      culled_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (bus.start) begin
            ax_reg    <= bus.ax;
            ay_reg    <= bus.ay;
            bx_reg    <= bus.bx;
            by_reg    <= bus.by;
            cx_reg    <= bus.cx;
            cy_reg    <= bus.cy;
            busy_reg  <= 1'b1;
            state_reg <= LATCH;
          end
        end
        LATCH: begin
          a_reg[0]     <= $signed({1'b0, ay_reg}) - $signed({1'b0, by_reg});
          b_reg[0]     <= $signed({1'b0, bx_reg}) - $signed({1'b0, ax_reg});
          a_reg[1]     <= $signed({1'b0, by_reg}) - $signed({1'b0, cy_reg});
          b_reg[1]     <= $signed({1'b0, cx_reg}) - $signed({1'b0, bx_reg});
          a_reg[2]     <= $signed({1'b0, cy_reg}) - $signed({1'b0, ay_reg});
          b_reg[2]     <= $signed({1'b0, ax_reg}) - $signed({1'b0, cx_reg});
          prod_cnt_reg <= '0;
          step_reg     <= '0;
          state_reg    <= MUL;
        end
        MUL: begin
          acc_reg <= acc_next;
          if (step_reg == 4'd10) begin
            step_reg <= '0;
            if (!prod_cnt_reg[0]) begin
              first_reg <= acc_next;
            end else begin
              c_reg[prod_cnt_reg[2:1]] <= c_diff[20:0];
            end
            if (prod_cnt_reg == 3'd5) begin
              state_reg <= SUM;
            end else begin
              prod_cnt_reg <= prod_cnt_reg + 3'd1;
            end
          end else begin
            step_reg <= step_reg + 4'd1;
          end
        end
        SUM: begin
          if (drop) begin
            culled_reg <= 1'b1;
            busy_reg   <= 1'b0;
            state_reg  <= IDLE;
          end else begin
            for (int i = 0; i < 3; i++) begin
              a_out_reg[i] <= a_sel[i];
              b_out_reg[i] <= b_sel[i];
              c_out_reg[i] <= c_sel[i];
            end
            area_reg      <= flip ? -area_sum : area_sum;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.culled    = culled_reg;
  assign bus.a0        = a_out_reg[0];
  assign bus.b0        = b_out_reg[0];
  assign bus.a1        = a_out_reg[1];
  assign bus.b1        = b_out_reg[1];
  assign bus.a2        = a_out_reg[2];
  assign bus.b2        = b_out_reg[2];
  assign bus.c0        = c_out_reg[0];
  assign bus.c1        = c_out_reg[1];
  assign bus.c2        = c_out_reg[2];
  assign bus.area      = area_reg;

endmodule
